// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the UART TX FIFO write port. A grant covers a whole
// message, capped at MAX_BURST bytes, so bytes from different sources never interleave.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 fifo_full,
  output logic                 fifo_wr_en,
  output logic [7:0]           fifo_wdata,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic [7:0]           burst_cnt
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;
  logic [2:0]         grant_id_q, grant_id_d;
  logic [7:0]         burst_cnt_q, burst_cnt_d;
  logic [NUM_REQ-1:0] owner_oh;
  logic               owner_valid, owner_last, xfer, release_msg;
  logic [7:0]         owner_data;
  logic               arb_found;
  logic [2:0]         arb_idx;
  logic [3:0]         scan_idx;
  logic [NUM_REQ-1:0] scan_vec;

  // One-hot owner mask; all zero while IDLE, so nothing can transfer there.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_owner
      assign owner_oh[gi] = (state_q == LOCK) && (grant_id_q == 3'(gi));
    end
  endgenerate

  assign req_ready   = fifo_full ? '0 : owner_oh;
  assign owner_valid = |(req_valid & owner_oh);
  assign owner_last  = |(req_last & owner_oh);
  assign xfer        = owner_valid && !fifo_full;
  assign release_msg = xfer && (owner_last || ({1'b0, burst_cnt_q} + 9'd1 >= 9'(MAX_BURST)));

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_data = owner_data | (req_data[8*i +: 8] & {8{owner_oh[i]}});
    end
  end

  assign fifo_wr_en = xfer;
  assign fifo_wdata = xfer ? owner_data : 8'h00;

  // First valid requester at or after rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    scan_idx  = '0;
    scan_vec  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + 4'(k);
      if (scan_idx >= 4'(NUM_REQ)) scan_idx = scan_idx - 4'(NUM_REQ);
      scan_vec = req_valid >> scan_idx;
      if (!arb_found && scan_vec[0]) begin
        arb_found = 1'b1;
        arb_idx   = scan_idx[2:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        burst_cnt_d = '0;
        if (arb_found) begin
          state_d    = LOCK;
          grant_id_d = arb_idx;
        end
      end
      LOCK: begin
        if (xfer) begin
          if (burst_cnt_q != 8'(MAX_BURST)) burst_cnt_d = burst_cnt_q + 8'd1;
          if (release_msg) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_id_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign grant_id  = grant_id_q;
  assign busy      = (state_q == LOCK);
  assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a directed vector table, hand sequences for the
// stall/drop/reset corners, and randomized traffic against a message-level model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int MB = 16;

  logic           HCLK = 1'b0;
  logic           HRESETn;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic           fifo_full, fifo_wr_en, busy;
  logic [7:0]     fifo_wdata, burst_cnt;
  logic [2:0]     grant_id;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_wdata(fifo_wdata), .grant_id(grant_id), .busy(busy), .burst_cnt(burst_cnt)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [N-1:0]   v;
    logic [8*N-1:0] d;
    logic [N-1:0]   l;
    logic           f;
    logic           wr;
    logic [7:0]     wd;
    logic [N-1:0]   rdy;
    logic           bz;
    logic [2:0]     gid;
    logic [7:0]     cnt;
  } vec_t;
  vec_t vec[11];

  // Reference model: who owns the port, where the next search starts, bytes sent.
  bit m_busy, m_xfer;
  int m_owner, m_ptr, m_cnt, m_xo;

  // Per-requester pending messages and the observed FIFO write log.
  logic [7:0] qd[N][$];
  bit         ql[N][$];
  bit         pres[N];
  logic [7:0] log_d[$];
  int         log_g[$];
  int         log_c[$];
  int         gcyc = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += qd[i].size();
    return s;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_xfer = 0;
  endtask

  task automatic check_zero(string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".wr_en"}, 32'(fifo_wr_en), 32'd0);
    chk({tag, ".wdata"}, 32'(fifo_wdata), 32'd0);
    chk({tag, ".ready"}, 32'(req_ready), 32'd0);
    chk({tag, ".grant"}, 32'(grant_id), 32'd0);
    chk({tag, ".cnt"}, 32'(burst_cnt), 32'd0);
  endtask

  // One clock: compare DUT against the model mid-cycle, then advance the model.
  task automatic model_check(string tag);
    logic [31:0] exp_rdy, exp_wd;
    @(negedge HCLK);
    m_xfer  = m_busy && req_valid[m_owner] && !fifo_full;
    m_xo    = m_owner;
    exp_rdy = (m_busy && !fifo_full) ? (32'd1 << m_owner) : 32'd0;
    exp_wd  = m_xfer ? 32'(req_data[8*m_owner +: 8]) : 32'd0;
    chk({tag, ".wr_en"}, 32'(fifo_wr_en), 32'(m_xfer));
    chk({tag, ".wdata"}, 32'(fifo_wdata), exp_wd);
    chk({tag, ".ready"}, 32'(req_ready), exp_rdy);
    chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
    chk({tag, ".cnt"}, 32'(burst_cnt), 32'(m_cnt));
    if (m_busy) chk({tag, ".grant"}, 32'(grant_id), 32'(m_owner));
    if (fifo_wr_en === 1'b1) begin
      log_d.push_back(fifo_wdata);
      log_g.push_back(int'(grant_id));
      log_c.push_back(gcyc);
    end
    gcyc++;
    if (!m_busy) begin
      m_cnt = 0;
      for (int k = 0; k < N; k++) begin
        if (!m_busy && req_valid[(m_ptr + k) % N]) begin
          m_busy  = 1;
          m_owner = (m_ptr + k) % N;
        end
      end
    end else if (m_xfer) begin
      if (m_cnt < MB) m_cnt++;
      if (req_last[m_owner] || m_cnt == MB) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic clear_logs();
    log_d.delete(); log_g.delete(); log_c.delete();
  endtask

  task automatic do_reset(string tag);
    HRESETn = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      qd[i].delete(); ql[i].delete(); pres[i] = 0;
    end
    @(posedge HCLK);
    #1;
    check_zero(tag);
    HRESETn = 1'b1;
    model_reset();
    clear_logs();
  endtask

  // Present queued bytes (holding each until accepted) until every queue drains.
  task automatic run_queues(string tag, int bound, bit rand_full, bit rand_pres,
                            int full_from, int full_to);
    int cyc = 0;
    while (pending() > 0 && cyc < bound) begin
      for (int i = 0; i < N; i++) begin
        if (!pres[i] && qd[i].size() > 0 && (!rand_pres || $urandom_range(3) != 0)) pres[i] = 1;
        req_valid[i]       = pres[i];
        req_data[8*i +: 8] = pres[i] ? qd[i][0] : 8'h00;
        req_last[i]        = pres[i] ? ql[i][0] : 1'b0;
      end
      fifo_full = rand_full ? ($urandom_range(3) == 0) : (cyc >= full_from && cyc < full_to);
      model_check(tag);
      if (m_xfer) begin
        void'(qd[m_xo].pop_front());
        void'(ql[m_xo].pop_front());
        pres[m_xo] = 0;
      end
      cyc++;
    end
    chk({tag, ".drained"}, 32'(pending()), 32'd0);
    req_valid = '0; req_last = '0; fifo_full = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int total;
    int exp_g[4];
    exp_g = '{0, 1, 0, 1};

    // Requester 2 sends "ABC", then 0 and 3 compete with rr_ptr at 3.
    vec[0]  = '{4'b0100, 32'h0041_0000, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 3'd0, 8'd0};
    vec[1]  = '{4'b0100, 32'h0041_0000, 4'b0000, 1'b0, 1'b1, 8'h41, 4'b0100, 1'b1, 3'd2, 8'd0};
    vec[2]  = '{4'b0100, 32'h0042_0000, 4'b0000, 1'b0, 1'b1, 8'h42, 4'b0100, 1'b1, 3'd2, 8'd1};
    vec[3]  = '{4'b0100, 32'h0043_0000, 4'b0100, 1'b0, 1'b1, 8'h43, 4'b0100, 1'b1, 3'd2, 8'd2};
    vec[4]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 3'd2, 8'd3};
    vec[5]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 3'd2, 8'd0};
    vec[6]  = '{4'b1001, 32'hD300_00A0, 4'b1001, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 3'd2, 8'd0};
    vec[7]  = '{4'b1001, 32'hD300_00A0, 4'b1001, 1'b0, 1'b1, 8'hD3, 4'b1000, 1'b1, 3'd3, 8'd0};
    vec[8]  = '{4'b0001, 32'h0000_00A0, 4'b0001, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 3'd3, 8'd1};
    vec[9]  = '{4'b0001, 32'h0000_00A0, 4'b0001, 1'b0, 1'b1, 8'hA0, 4'b0001, 1'b1, 3'd0, 8'd0};
    vec[10] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 3'd0, 8'd1};

    HRESETn = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    #2 HRESETn = 1'b0;
    #1 check_zero("reset");
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    model_reset();

    for (int r = 0; r < 11; r++) begin
      req_valid = vec[r].v; req_data = vec[r].d; req_last = vec[r].l; fifo_full = vec[r].f;
      @(negedge HCLK);
      chk($sformatf("vec%0d.wr_en", r), 32'(fifo_wr_en), 32'(vec[r].wr));
      chk($sformatf("vec%0d.wdata", r), 32'(fifo_wdata), 32'(vec[r].wd));
      chk($sformatf("vec%0d.ready", r), 32'(req_ready), 32'(vec[r].rdy));
      chk($sformatf("vec%0d.busy", r), 32'(busy), 32'(vec[r].bz));
      chk($sformatf("vec%0d.cnt", r), 32'(burst_cnt), 32'(vec[r].cnt));
      if (vec[r].bz) chk($sformatf("vec%0d.grant", r), 32'(grant_id), 32'(vec[r].gid));
      @(posedge HCLK);
      #1;
    end
    $display("vector table done: %0d checks, %0d errors", checks, errors);

    // Two simultaneous one-byte requesters, twice: order 0,1 then 0,1 again.
    do_reset("rr.reset");
    for (int round = 0; round < 2; round++) begin
      qd[0].push_back(8'h10 + 8'(round)); ql[0].push_back(1'b1);
      qd[1].push_back(8'h20 + 8'(round)); ql[1].push_back(1'b1);
      run_queues("rr", 50, 1'b0, 1'b0, 0, 0);
    end
    chk("rr.count", 32'(log_g.size()), 32'd4);
    if (log_g.size() == 4)
      for (int i = 0; i < 4; i++) chk($sformatf("rr.order%0d", i), 32'(log_g[i]), 32'(exp_g[i]));
    $display("round-robin order done: %0d checks, %0d errors", checks, errors);

    // 20-byte message from requester 3 split by the burst cap.
    do_reset("burst.reset");
    for (int b = 0; b < 20; b++) begin
      qd[3].push_back(8'(b)); ql[3].push_back(b == 19);
    end
    run_queues("burst", 100, 1'b0, 1'b0, 0, 0);
    chk("burst.count", 32'(log_d.size()), 32'd20);
    if (log_d.size() == 20) begin
      for (int b = 0; b < 20; b++) chk($sformatf("burst.byte%0d", b), 32'(log_d[b]), 32'(b));
      chk("burst.gap", 32'(log_c[16] - log_c[15]), 32'd2);
      chk("burst.gap_before", 32'(log_c[15] - log_c[14]), 32'd1);
    end
    $display("burst cap done: %0d checks, %0d errors", checks, errors);

    // FIFO full for 5 cycles after the second byte.
    do_reset("full.reset");
    for (int b = 0; b < 6; b++) begin
      qd[1].push_back(8'h60 + 8'(b)); ql[1].push_back(b == 5);
    end
    run_queues("full", 100, 1'b0, 1'b0, 3, 8);
    chk("full.count", 32'(log_d.size()), 32'd6);
    if (log_d.size() == 6) begin
      for (int b = 0; b < 6; b++) chk($sformatf("full.byte%0d", b), 32'(log_d[b]), 32'h60 + 32'(b));
      chk("full.gap", 32'(log_c[2] - log_c[1]), 32'd6);
    end
    $display("fifo full stall done: %0d checks, %0d errors", checks, errors);

    // Owner 1 goes quiet for 4 cycles while requester 2 waits.
    do_reset("drop.reset");
    req_valid = 4'b0010; req_data = 32'h0000_5100; req_last = 4'b0000;
    model_check("drop.arb");
    model_check("drop.b0");
    req_valid = 4'b0100; req_data = 32'h005A_0000; req_last = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      model_check($sformatf("drop.wait%0d", c));
      chk($sformatf("drop.busy%0d", c), 32'(busy), 32'd1);
      chk($sformatf("drop.grant%0d", c), 32'(grant_id), 32'd1);
    end
    req_valid = 4'b0110; req_data = 32'h005A_5200; req_last = 4'b0110;
    model_check("drop.b1");
    req_valid = 4'b0100; req_data = 32'h005A_0000; req_last = 4'b0100;
    model_check("drop.arb2");
    model_check("drop.r2");
    chk("drop.r2_grant_seen", 32'(log_g.size() == 3 ? log_g[2] : -1), 32'd2);
    $display("owner drop done: %0d checks, %0d errors", checks, errors);

    // Reset while requester 2 owns the port with rr_ptr at 2.
    do_reset("mid.reset");
    req_valid = 4'b0010; req_data = 32'h0000_7000; req_last = 4'b0010;
    model_check("mid.arb1");
    model_check("mid.r1");
    req_valid = 4'b0100; req_data = 32'h0071_0000; req_last = 4'b0000;
    model_check("mid.arb2");
    model_check("mid.r2");
    chk("mid.locked", 32'(busy), 32'd1);
    HRESETn = 1'b0;
    #1 check_zero("mid.async");
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    model_reset();
    req_valid = 4'b0110; req_data = 32'h0073_7200; req_last = 4'b0110;
    model_check("mid.arb3");
    chk("mid.grant_after_reset", 32'(grant_id), 32'd1);
    model_check("mid.r1b");
    $display("reset mid-message done: %0d checks, %0d errors", checks, errors);

    // Randomized traffic with random presentation and FIFO back-pressure.
    do_reset("rand.reset");
    for (int i = 0; i < N; i++)
      for (int m = 0; m < 4; m++) begin
        int len = $urandom_range(1, 20);
        for (int b = 0; b < len; b++) begin
          qd[i].push_back(8'($urandom)); ql[i].push_back(b == len - 1);
        end
      end
    total = pending();
    run_queues("rand", 4000, 1'b1, 1'b1, 0, 0);
    chk("rand.bytes", 32'(log_d.size()), 32'(total));
    $display("random traffic done: %0d bytes, %0d checks, %0d errors", total, checks, errors);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single AHB UART transmit FIFO write port among NUM_REQ byte-stream requesters (e.g. CPU bridge, debug printer, DMA). Holds a grant for a whole message, up to MAX_BURST bytes, so bytes from different sources never interleave on the serial line. Sits between the requesters and the UART TX FIFO; it never reads FIFO contents and only honours the FIFO full flag.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 16, max bytes per grant before a forced release (1..255)

Ports:
HCLK  in  1  system clock
HRESETn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  requester i has a byte available
req_data  in  8*NUM_REQ  byte of requester i in bits [8i+7:8i]
req_last  in  NUM_REQ  byte of requester i ends its message
req_ready  out  NUM_REQ  byte of requester i accepted this cycle when valid
fifo_full  in  1  UART TX FIFO full
fifo_wr_en  out  1  write strobe to TX FIFO
fifo_wdata  out  8  byte to TX FIFO
grant_id  out  3  index of current owner (valid when busy)
busy  out  1  grant held (state LOCK)
burst_cnt  out  8  bytes written in current grant

Behaviour:
- Clock/reset: one clock HCLK; HRESETn asynchronous active-low. On reset: state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0, busy=0. fifo_wr_en, req_ready and fifo_wdata are therefore 0.
- FSM states: IDLE, LOCK.
- IDLE:
  - If any req_valid is set, select the first i with req_valid[i], searching upward from rr_ptr with wrap at NUM_REQ.
  - Next cycle: state=LOCK, grant_id=i, burst_cnt=0.
  - No transfer happens in IDLE. The arbitration cycle costs 1 cycle.
- LOCK:
  - req_ready[grant_id] = !fifo_full. All other req_ready bits are 0. This is combinational from state, grant_id and fifo_full.
  - A transfer occurs when req_valid[grant_id] && req_ready[grant_id].
  - fifo_wr_en = transfer, combinationally. fifo_wdata = req_data of grant_id. fifo_wdata is 0 when fifo_wr_en is 0.
  - Each transfer increments burst_cnt, which is 8 bits and saturates at MAX_BURST.
  - Release to IDLE on the clock after a transfer with req_last[grant_id]=1, or a transfer that makes burst_cnt reach MAX_BURST.
  - On release: rr_ptr = (grant_id+1) mod NUM_REQ, and burst_cnt clears in IDLE.
- Owner deasserting req_valid while in LOCK: the grant is held, waiting indefinitely. A message must complete or hit MAX_BURST.
- fifo_full while in LOCK: stall, no write, grant held, burst_cnt unchanged.
- Simultaneous requests in IDLE: strict round-robin from rr_ptr. After owner k releases, k has lowest priority.
- Requests from non-owners in LOCK: ignored, with req_ready=0. A requester must hold valid and data stable until accepted.
- last and MAX_BURST on the same transfer: single release, same rr_ptr update.
- Reset mid-message: immediate return to IDLE, rr_ptr=0. The partial message already written to the FIFO is not recalled.
- Throughput: in LOCK with FIFO not full, 1 byte/cycle. The only inter-message gap is the 1 IDLE cycle.

Test Plan:
- Single requester 2 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) with FIFO empty -> IDLE 1 cycle, grant_id=2. fifo_wr_en high 3 consecutive cycles with 0x41,0x42,0x43. Return to IDLE, rr_ptr=3.
- Requesters 0 and 1 both valid from reset, each 1-byte message -> grant order 0 then 1. Then with 0 and 1 requesting again, grant order 0 then 1 again, because rr_ptr=2 wraps to 0.
- Requester 3 streams 20 bytes 0x00..0x13 with last on the 20th byte -> release after 16 bytes (0x00..0x0F), burst_cnt=16. Re-arbitration wraps to 3, which alone is valid, and it writes 0x10..0x13.
- fifo_full asserted for 5 cycles mid-message -> no fifo_wr_en and req_ready=0 during those cycles. The next byte is written the cycle after full drops. No byte is lost or duplicated.
- Owner 1 drops valid for 4 cycles mid-message while requester 2 is valid -> busy stays 1, grant_id=1, req_ready[2]=0 throughout.
- HRESETn pulsed low during LOCK -> outputs immediately 0 (asynchronous). After release, requester 1 and 2 valid -> grant goes to 1 (rr_ptr=0).
